// File: rtl/cmul_pkg.sv
// cmul_pkg: shared sample type, FSM states and defaults for the complex-multiply pair joiner
package cmul_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  typedef logic [2*DEF_DATA_WIDTH-1:0] sample_t;
  typedef enum logic [1:0] {JOIN, DRAIN_A, DRAIN_B} join_state_e;
endpackage

// File: rtl/cmul_sample_fifo.sv
// cmul_sample_fifo: synchronous {tlast, tdata} FIFO with full/empty and async active-low reset
module cmul_sample_fifo
  import cmul_pkg::*;
#(
  parameter int WIDTH = 2*DEF_DATA_WIDTH + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign push    = wr_en & !full;
  assign pop     = rd_en & !empty;
  assign rd_data = mem[rd_ptr];
  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage needs no reset; empty masks stale contents
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/cmul_pair_join.sv
// cmul_pair_join: joins two buffered AXI-Stream sample streams into operand pairs; CMUL_PAIR_JOIN_RESYNC_EN adds tlast resync
module cmul_pair_join
  import cmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2*DATA_WIDTH-1:0] a_tdata,
  input  logic                    a_tlast,
  input  logic                    a_tvalid,
  output logic                    a_tready,
  input  logic [2*DATA_WIDTH-1:0] b_tdata,
  input  logic                    b_tlast,
  input  logic                    b_tvalid,
  output logic                    b_tready,
  output logic [2*DATA_WIDTH-1:0] adata,
  output logic [2*DATA_WIDTH-1:0] bdata,
  output logic                    out_tlast,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    mismatch,
  output logic [CNT_WIDTH-1:0]    mismatch_cnt
);
  localparam int SW = 2*DATA_WIDTH;
  logic [SW:0] a_head, b_head;
  logic a_full, a_empty, a_pop, a_hlast;
  logic b_full, b_empty, b_pop, b_hlast;
  logic join_pop, last_diff;
  join_state_e state, state_nx;
  cmul_sample_fifo #(.WIDTH(SW+1), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(reset_n), .wr_en(a_tvalid), .wr_data({a_tlast, a_tdata}),
    .rd_en(a_pop), .rd_data(a_head), .full(a_full), .empty(a_empty)
  );
  cmul_sample_fifo #(.WIDTH(SW+1), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(reset_n), .wr_en(b_tvalid), .wr_data({b_tlast, b_tdata}),
    .rd_en(b_pop), .rd_data(b_head), .full(b_full), .empty(b_empty)
  );
  assign adata      = a_head[SW-1:0];
  assign bdata      = b_head[SW-1:0];
  assign a_hlast    = a_head[SW];
  assign b_hlast    = b_head[SW];
  assign a_tready   = !a_full;
  assign b_tready   = !b_full;
  assign out_tvalid = (state == JOIN) & !a_empty & !b_empty;
  assign join_pop   = out_tvalid & out_tready;
  assign last_diff  = a_hlast ^ b_hlast;
  assign a_pop      = join_pop | ((state == DRAIN_A) & !a_empty);
  assign b_pop      = join_pop | ((state == DRAIN_B) & !b_empty);
`ifdef CMUL_PAIR_JOIN_RESYNC_EN
  assign out_tlast = a_hlast | b_hlast;
  // a mismatched pop drains the lagging stream up to and including its tlast
  always_comb
    state_nx = (join_pop & last_diff) ? (a_hlast ? DRAIN_B : DRAIN_A) :
               ((state == DRAIN_A) & a_pop & a_hlast) ? JOIN :
               ((state == DRAIN_B) & b_pop & b_hlast) ? JOIN : state;
`else
  assign out_tlast = a_hlast;
  assign state_nx  = JOIN;
`endif
  // state, mismatch pulse and saturating mismatch count
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= JOIN;
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      state        <= state_nx;
      mismatch     <= join_pop & last_diff;
      mismatch_cnt <= (join_pop & last_diff & ~&mismatch_cnt) ? mismatch_cnt + CNT_WIDTH'(1) : mismatch_cnt;
    end
endmodule

// File: doc/cmul_pair_join.md
Name: cmul_pair_join

Overview:
- Transmit-side feeder for the complex-multiply datapath.
- Accepts two independent AXI-Stream complex sample streams, A and B, each with its own handshake, and buffers each in a small FIFO.
- Emits joined operand pairs on a single shared valid/last/ready handshake, matching the multiplier's joint input interface.
- Detects packet-boundary (tlast) misalignment between A and B; optionally resynchronises.

Parameters:
- DATA_WIDTH, 16, bits per I or Q component; a sample is 2*DATA_WIDTH, {I,Q} with I in the MSBs.
- FIFO_DEPTH, 4, entries per input FIFO; power of two, >= 2.
- CNT_WIDTH, 16, width of the saturating mismatch counter.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- a_tdata  in  2*DATA_WIDTH  stream A sample.
- a_tlast  in  1  stream A end of packet.
- a_tvalid  in  1  stream A valid.
- a_tready  out  1  stream A ready.
- b_tdata  in  2*DATA_WIDTH  stream B sample.
- b_tlast  in  1  stream B end of packet.
- b_tvalid  in  1  stream B valid.
- b_tready  out  1  stream B ready.
- adata  out  2*DATA_WIDTH  joined operand A (head of FIFO A).
- bdata  out  2*DATA_WIDTH  joined operand B (head of FIFO B).
- out_tlast  out  1  joined end of packet.
- out_tvalid  out  1  joined pair valid.
- out_tready  in  1  downstream ready.
- mismatch  out  1  one-cycle pulse when a pair is popped with differing A/B tlast.
- mismatch_cnt  out  CNT_WIDTH  saturating count of mismatch pulses.

Behaviour:
- Reset (async assert, sync release): FIFO pointers and occupancy 0, state JOIN, out_tvalid 0, mismatch 0, mismatch_cnt 0, a_tready/b_tready 1. adata/bdata/out_tlast are don't-care while out_tvalid = 0.
- Reset asserted mid-packet discards all buffered data. No partial pair is emitted after release.
- Push A on a_tvalid & a_tready; a_tready = !fullA. Identical rule for B. A full FIFO deasserts ready even if a pop occurs in the same cycle; there is no pass-through.
- Simultaneous push and pop on a non-full FIFO: occupancy unchanged, both succeed.
- Latency: a sample pushed in cycle N is visible at the FIFO head in cycle N+1. Minimum input-to-out_tvalid latency is 1 cycle.
- State JOIN:
  - out_tvalid = !emptyA & !emptyB.
  - out_tlast = head tlast of A.
  - Pop both FIFOs on out_tvalid & out_tready.
  - out_tvalid, once high, holds with stable data until accepted.
- Mismatch: on a JOIN pop with headA.tlast != headB.tlast, mismatch = 1 in the following cycle. mismatch_cnt increments, saturating at all-ones.
- Throughput: 1 pair/cycle sustained when both inputs stream and out_tready = 1.
- Empty/backpressure: either FIFO empty -> out_tvalid 0. out_tready low -> FIFOs fill, then the respective tready drops.

Optional Feature:
- Macro: CMUL_PAIR_JOIN_RESYNC_EN.
- With the macro, the FSM has states JOIN, DRAIN_A, DRAIN_B.
  - A mismatched pop with A.tlast = 1 (B not last) -> DRAIN_B.
  - A mismatched pop with B.tlast = 1 -> DRAIN_A.
  - In DRAIN_x: out_tvalid = 0; FIFO x pops one entry per cycle whenever non-empty, ignoring out_tready. Popping the entry with tlast = 1 (inclusive) returns to JOIN the next cycle. The other FIFO keeps accepting pushes.
  - The mismatched pair itself is emitted with out_tlast = 1 in the resync build, i.e. A.tlast | B.tlast.
  - Reset returns to JOIN.
- Without the macro: JOIN only; mismatch is flagged and counted, and out_tlast = A tlast.

Decomposition:
- Shared package cmul_pkg:
  - sample typedef (2*DATA_WIDTH packed {I,Q});
  - FSM state enum {JOIN, DRAIN_A, DRAIN_B};
  - constants for default DATA_WIDTH and FIFO_DEPTH.
- One natural sub-module, cmul_sample_fifo: synchronous FIFO of {tlast, tdata}, parameterised width and depth, with full/empty and an async active-low reset. It is instantiated twice.

Test Plan:
- Reset: hold reset_n = 0 with a_tvalid = b_tvalid = 1 -> out_tvalid 0, mismatch_cnt 0, a_tready = b_tready = 1 after release.
- Streaming: A = 1..8, B = 101..108, both tlast on the 8th sample, out_tready = 1 -> 8 pairs (1,101)...(8,108) on consecutive cycles, out_tlast only on (8,108), mismatch never pulses.
- Skew: A pushed 3 cycles before B -> first out_tvalid 1 cycle after the first B push; pairs correctly aligned.
- Backpressure: out_tready = 0, push 6 A samples with FIFO_DEPTH = 4 -> a_tready drops after 4 accepted; after release all 4 emitted in order, then remaining 2.
- Mismatch, non-resync build: A packet length 3, B packet length 4 -> mismatch pulse once after the 3rd pair, mismatch_cnt = 1, out_tlast on the 3rd pair.
- Mismatch, CMUL_PAIR_JOIN_RESYNC_EN build, same stimulus -> B's 4th sample discarded with no out_tvalid. The next packets (A = 10,11; B = 20,21, both tlast on the 2nd) emit (10,20), (11,21) with out_tlast on (11,21).
